uart_led_cmd_ctrl: RTL and testbench
====================================

Name: uart_led_cmd_ctrl

Overview:
- Command sequencer between the UART receiver and the LED outputs.
- Consumes received bytes (write_done strobe + byte_in) as a 1- or 2-byte command protocol.
- Drives the 8 LEDs in OFF, STATIC, BLINK or ROTATE mode with a programmable tick period.
- Replaces direct byte-to-LED mapping; sits directly downstream of the UART receiver.

Parameters:
- TICK_DIV, 1000000, clock cycles per display tick (10 ms at 100 MHz); must be >= 2.
- TIMEOUT, 100000000, cycles allowed between opcode and operand byte before the command is aborted; must be >= 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous reset, active low.
- write_done  in  1  one-cycle strobe from UART receiver; byte_in is valid in that cycle.
- byte_in  in  8  received byte.
- led_out  out  8  registered LED drive.
- mode  out  2  current display mode: 00 OFF, 01 STATIC, 10 BLINK, 11 ROTATE.
- cmd_err  out  1  one-cycle pulse on a bad opcode or an operand timeout.

Behaviour:
- Reset (async assert, sync-free release): led_out=0, mode=00, cmd_err=0, pattern=0, rot_reg=0, period=1, phase=1, prescaler=0, tick count=0, timeout count=0, parser=P_OPCODE.
- Reset mid-command discards any partially received command.
- Parser FSM, P_OPCODE state, on write_done:
  - 0x00 (OFF): mode<=00; no operand; stay in P_OPCODE.
  - 0x01 (SET), 0x02 (BLINK), 0x03 (ROTATE): latch opcode, timeout count<=0, go to P_OPERAND.
  - Any other value: cmd_err=1 for exactly one cycle; all state unchanged; stay in P_OPCODE.
- Parser FSM, P_OPERAND state:
  - write_done commits the command, then the parser returns to P_OPCODE.
    - SET: pattern<=byte_in, mode<=01.
    - BLINK: period<=max(byte_in,1), mode<=10, phase<=1.
    - ROTATE: period<=max(byte_in,1), mode<=11, rot_reg<=pattern.
    - BLINK and ROTATE commits also clear the prescaler and tick count.
  - Otherwise the timeout count increments each cycle. When it reaches TIMEOUT-1 with no write_done: cmd_err pulses for one cycle, parser returns to P_OPCODE, display state unchanged.
  - write_done in the same cycle the timeout limit is reached: write_done wins; no error.
- Timing: write_done sampled at edge N, so mode, pattern and period update at edge N, and led_out reflects the new state at edge N+1.
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick=1 in the cycle the prescaler equals TICK_DIV-1. Free-running in every mode.
- Event generation: in BLINK/ROTATE the tick count increments on each tick. When a tick arrives with tick count = period-1, an event fires and tick count<=0. Events are therefore exactly every period*TICK_DIV cycles after a commit.
  - BLINK event: phase toggles.
  - ROTATE event: rot_reg rotates left by 1 (bit7 -> bit0).
- A commit in the same cycle as an event: commit wins; the event is dropped.
- led_out (registered, next cycle):
  - OFF: 0x00.
  - STATIC: pattern.
  - BLINK: pattern when phase=1, else 0x00.
  - ROTATE: rot_reg.
- SET while in BLINK or ROTATE switches to STATIC; period is retained.
- OFF keeps pattern and period. A later BLINK or ROTATE reuses the stored pattern.
- period is 8-bit; operand 0 is treated as 1; maximum 255 ticks per event.

Test Plan:
Bench uses TICK_DIV=4, TIMEOUT=50.
1. Reset, then send 0x01,0xA5 → mode=01, led_out=0xA5 one cycle after the second write_done; cmd_err stays 0.
2. After SET 0x81, send 0x03,0x02 → led_out sequence 0x81, 0x03, 0x06, 0x0C, changing every 8 cycles; mode=11.
3. After SET 0xF0, send 0x02,0x00 → period=1; led_out alternates 0xF0/0x00 every 4 cycles.
4. Send 0x7E → cmd_err high exactly 1 cycle; led_out and mode unchanged. Then send 0x01 with no operand for 50 cycles → one cmd_err pulse; the next 0x01,0x3C is accepted and yields led_out=0x3C.
5. Operand write_done coincident with the timeout limit → command commits and no cmd_err. BLINK commit coincident with an event → phase=1, led_out=pattern.
6. Assert rst_n=0 between opcode 0x01 and its operand, then release and send 0x55 → cmd_err pulse (0x55 is not a valid opcode); led_out=0x00, mode=00.

Source files
------------

// File: rtl/uart_led_cmd_ctrl.sv
// Command sequencer between the UART receiver and the LEDs: parses 1/2-byte
// commands and drives the LEDs in OFF, STATIC, BLINK or ROTATE mode.
module uart_led_cmd_ctrl #(
  parameter int unsigned TICK_DIV = 1000000,
  parameter int unsigned TIMEOUT  = 100000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       write_done,
  input  logic [7:0] byte_in,
  output logic [7:0] led_out,
  output logic [1:0] mode,
  output logic       cmd_err
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    M_OFF    = 2'b00,
    M_STATIC = 2'b01,
    M_BLINK  = 2'b10,
    M_ROTATE = 2'b11
  } mode_e;

  typedef enum logic {
    P_OPCODE  = 1'b0,
    P_OPERAND = 1'b1
  } pstate_e;

  pstate_e       pstate_q, pstate_d;
  mode_e         mode_q, mode_d;
  logic [1:0]    op_q, op_d;
  logic [7:0]    pattern_q, pattern_d;
  logic [7:0]    rot_q, rot_d;
  logic [7:0]    period_q, period_d;
  logic          phase_q, phase_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    tick_cnt_q, tick_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]    led_q, led_d;
  logic          err_q, err_d;

  logic          tick;
  logic          animating;
  logic          event_hit;
  logic [7:0]    operand_period;

  assign tick           = (presc_q == PRESC_MAX);
  assign animating      = (mode_q == M_BLINK) || (mode_q == M_ROTATE);
  assign event_hit      = animating && tick && (tick_cnt_q == (period_q - 8'd1));
  assign operand_period = (byte_in == 8'h00) ? 8'd1 : byte_in;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pstate_q   <= P_OPCODE;
      mode_q     <= M_OFF;
      op_q       <= 2'b00;
      pattern_q  <= 8'h00;
      rot_q      <= 8'h00;
      period_q   <= 8'd1;
      phase_q    <= 1'b1;
      presc_q    <= '0;
      tick_cnt_q <= 8'd0;
      to_cnt_q   <= '0;
      led_q      <= 8'h00;
      err_q      <= 1'b0;
    end else begin
      pstate_q   <= pstate_d;
      mode_q     <= mode_d;
      op_q       <= op_d;
      pattern_q  <= pattern_d;
      rot_q      <= rot_d;
      period_q   <= period_d;
      phase_q    <= phase_d;
      presc_q    <= presc_d;
      tick_cnt_q <= tick_cnt_d;
      to_cnt_q   <= to_cnt_d;
      led_q      <= led_d;
      err_q      <= err_d;
    end
  end

  // Parser, display timebase and LED selection
  always_comb begin
    pstate_d   = pstate_q;
    mode_d     = mode_q;
    op_d       = op_q;
    pattern_d  = pattern_q;
    rot_d      = rot_q;
    period_d   = period_q;
    phase_d    = phase_q;
    tick_cnt_d = tick_cnt_q;
    to_cnt_d   = to_cnt_q;
    err_d      = 1'b0;
    presc_d    = tick ? '0 : presc_q + PW'(1);

    // Events first so that a commit below overrides them
    if (animating && tick) begin
      if (event_hit) begin
        tick_cnt_d = 8'd0;
        if (mode_q == M_BLINK) begin
          phase_d = ~phase_q;
        end else begin
          rot_d = {rot_q[6:0], rot_q[7]};
        end
      end else begin
        tick_cnt_d = tick_cnt_q + 8'd1;
      end
    end

    unique case (pstate_q)
      P_OPCODE: begin
        if (write_done) begin
          unique case (byte_in)
            8'h00: mode_d = M_OFF;
            8'h01, 8'h02, 8'h03: begin
              op_d     = byte_in[1:0];
              to_cnt_d = '0;
              pstate_d = P_OPERAND;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      P_OPERAND: begin
        if (write_done) begin
          pstate_d = P_OPCODE;
          case (op_q)
            2'd2: begin
              period_d   = operand_period;
              mode_d     = M_BLINK;
              phase_d    = 1'b1;
              presc_d    = '0;
              tick_cnt_d = 8'd0;
            end
            2'd3: begin
              period_d   = operand_period;
              mode_d     = M_ROTATE;
              rot_d      = pattern_q;
              presc_d    = '0;
              tick_cnt_d = 8'd0;
            end
            default: begin
              pattern_d = byte_in;
              mode_d    = M_STATIC;
            end
          endcase
        end else if (to_cnt_q == TO_MAX) begin
          err_d    = 1'b1;
          pstate_d = P_OPCODE;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end
      default: pstate_d = P_OPCODE;
    endcase

    unique case (mode_q)
      M_OFF:    led_d = 8'h00;
      M_STATIC: led_d = pattern_q;
      M_BLINK:  led_d = phase_q ? pattern_q : 8'h00;
      M_ROTATE: led_d = rot_q;
      default:  led_d = 8'h00;
    endcase
  end

  assign led_out = led_q;
  assign mode    = mode_q;
  assign cmd_err = err_q;

endmodule

// File: tb/tb_uart_led_cmd_ctrl.sv
// Self-checking bench for uart_led_cmd_ctrl: directed scenarios plus random
// command streams compared against an edge-indexed behavioural model.
module tb_uart_led_cmd_ctrl;

  localparam int unsigned TD = 4;
  localparam int unsigned TO = 50;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b0;
  logic       write_done = 1'b0;
  logic [7:0] byte_in    = 8'h00;
  logic [7:0] led_out;
  logic [1:0] mode;
  logic       cmd_err;

  int checks   = 0;
  int failures = 0;

  // Model: events happen at commit_edge + k*period*TD; display follows from k
  int unsigned edge_n    = 0;
  int unsigned m_base    = 0;
  int unsigned m_op_edge = 0;
  logic [1:0]  m_mode    = 2'b00;
  logic [1:0]  m_pend    = 2'b00;
  logic [7:0]  m_pat     = 8'h00;
  logic [7:0]  m_per     = 8'd1;
  logic [7:0]  m_rbase   = 8'h00;
  logic [7:0]  m_led     = 8'h00;
  logic        m_err     = 1'b0;

  uart_led_cmd_ctrl #(.TICK_DIV(TD), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .write_done (write_done),
    .byte_in    (byte_in),
    .led_out    (led_out),
    .mode       (mode),
    .cmd_err    (cmd_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] disp(input int unsigned e);
    int unsigned k;
    logic [15:0] d;
    k = (e - m_base) / (32'(m_per) * TD);
    case (m_mode)
      2'b00:   return 8'h00;
      2'b01:   return m_pat;
      2'b10:   return (k % 2 == 0) ? m_pat : 8'h00;
      default: begin
        d = {m_rbase, m_rbase} << (k % 8);
        return d[15:8];
      end
    endcase
  endfunction

  always begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      edge_n = 0; m_base = 0; m_op_edge = 0; m_mode = 2'b00; m_pend = 2'b00;
      m_pat = 8'h00; m_per = 8'd1; m_rbase = 8'h00; m_led = 8'h00; m_err = 1'b0;
    end else begin
      edge_n++;
      m_led = disp(edge_n - 1);
      m_err = 1'b0;
      if (m_pend == 2'b00) begin
        if (write_done) begin
          if (byte_in == 8'h00) m_mode = 2'b00;
          else if (byte_in <= 8'h03) begin
            m_pend    = byte_in[1:0];
            m_op_edge = edge_n;
          end else m_err = 1'b1;
        end
      end else if (write_done) begin
        if (m_pend == 2'd1) begin
          m_pat  = byte_in;
          m_mode = 2'b01;
        end else begin
          m_per  = (byte_in == 8'h00) ? 8'd1 : byte_in;
          m_mode = (m_pend == 2'd2) ? 2'b10 : 2'b11;
          m_base = edge_n;
          m_rbase = m_pat;
        end
        m_pend = 2'b00;
      end else if (edge_n - m_op_edge == TO) begin
        m_err  = 1'b1;
        m_pend = 2'b00;
      end
    end
  end

  task automatic send(input logic [7:0] b);
    write_done = 1'b1;
    byte_in    = b;
    @(negedge clk);
    write_done = 1'b0;
    byte_in    = 8'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; write_done = 1'b1; byte_in = 8'h01;
    repeat (3) @(negedge clk);
    checks++; if (led_out !== 8'h00) begin failures++; $display("FAIL reset_led got=%h exp=00", led_out); end
    checks++; if (mode !== 2'b00) begin failures++; $display("FAIL reset_mode got=%b exp=00", mode); end
    checks++; if (cmd_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", cmd_err); end
    write_done = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_set();
    send(8'h01); send(8'hA5);
    checks++; if (mode !== 2'b01) begin failures++; $display("FAIL set_mode got=%b exp=01", mode); end
    checks++; if (cmd_err !== 1'b0) begin failures++; $display("FAIL set_err got=%b exp=0", cmd_err); end
    @(negedge clk);
    checks++; if (led_out !== 8'hA5) begin failures++; $display("FAIL set_led got=%h exp=a5", led_out); end
  endtask

  task automatic test_rotate();
    logic [7:0] tbl [4];
    tbl = '{8'h81, 8'h03, 8'h06, 8'h0C};
    send(8'h01); send(8'h81); send(8'h03); send(8'h02);
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      checks++; if (led_out !== tbl[(i-1)/8]) begin failures++; $display("FAIL rot_led i=%0d got=%h exp=%h", i, led_out, tbl[(i-1)/8]); end
      checks++; if (mode !== 2'b11) begin failures++; $display("FAIL rot_mode i=%0d got=%b exp=11", i, mode); end
      checks++; if (led_out !== m_led) begin failures++; $display("FAIL rot_model i=%0d got=%h exp=%h", i, led_out, m_led); end
    end
  endtask

  task automatic test_blink();
    logic [7:0] exp_led;
    send(8'h01); send(8'hF0); send(8'h02); send(8'h00);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      exp_led = (((i - 1) / 4) % 2 == 0) ? 8'hF0 : 8'h00;
      checks++; if (led_out !== exp_led) begin failures++; $display("FAIL blink_led i=%0d got=%h exp=%h", i, led_out, exp_led); end
      checks++; if (mode !== 2'b10) begin failures++; $display("FAIL blink_mode i=%0d got=%b exp=10", i, mode); end
    end
  endtask

  task automatic test_errors();
    int pulses;
    int at;
    send(8'h7E);
    checks++; if (cmd_err !== 1'b1) begin failures++; $display("FAIL badop_err got=%b exp=1", cmd_err); end
    checks++; if (mode !== 2'b10) begin failures++; $display("FAIL badop_mode got=%b exp=10", mode); end
    @(negedge clk);
    checks++; if (cmd_err !== 1'b0) begin failures++; $display("FAIL badop_width got=%b exp=0", cmd_err); end
    checks++; if (led_out !== m_led) begin failures++; $display("FAIL badop_led got=%h exp=%h", led_out, m_led); end
    send(8'h01);
    pulses = 0; at = 0;
    for (int i = 1; i <= 55; i++) begin
      @(negedge clk);
      if (cmd_err === 1'b1) begin pulses++; at = i; end
    end
    checks++; if (pulses != 1) begin failures++; $display("FAIL timeout_pulses got=%0d exp=1", pulses); end
    checks++; if (at != 50) begin failures++; $display("FAIL timeout_cycle got=%0d exp=50", at); end
    send(8'h01); send(8'h3C);
    checks++; if (mode !== 2'b01) begin failures++; $display("FAIL after_to_mode got=%b exp=01", mode); end
    @(negedge clk);
    checks++; if (led_out !== 8'h3C) begin failures++; $display("FAIL after_to_led got=%h exp=3c", led_out); end
  endtask

  task automatic test_boundaries();
    send(8'h01);
    for (int i = 1; i <= 49; i++) begin
      @(negedge clk);
      checks++; if (cmd_err !== 1'b0) begin failures++; $display("FAIL edge_to_err i=%0d got=%b exp=0", i, cmd_err); end
    end
    send(8'h99);
    checks++; if (cmd_err !== 1'b0) begin failures++; $display("FAIL edge_to_commit_err got=%b exp=0", cmd_err); end
    checks++; if (mode !== 2'b01) begin failures++; $display("FAIL edge_to_mode got=%b exp=01", mode); end
    @(negedge clk);
    checks++; if (led_out !== 8'h99) begin failures++; $display("FAIL edge_to_led got=%h exp=99", led_out); end
    checks++; if (cmd_err !== 1'b0) begin failures++; $display("FAIL edge_to_late_err got=%b exp=0", cmd_err); end
    // Second BLINK commit lands on the first event of the first one
    send(8'h02); send(8'h01);
    repeat (2) @(negedge clk);
    send(8'h02); send(8'h01);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checks++; if (led_out !== 8'h99) begin failures++; $display("FAIL commit_vs_event i=%0d got=%h exp=99", i, led_out); end
    end
  endtask

  task automatic test_reset_mid();
    send(8'h01);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(8'h55);
    checks++; if (cmd_err !== 1'b1) begin failures++; $display("FAIL rstmid_err got=%b exp=1", cmd_err); end
    checks++; if (mode !== 2'b00) begin failures++; $display("FAIL rstmid_mode got=%b exp=00", mode); end
    @(negedge clk);
    checks++; if (led_out !== 8'h00) begin failures++; $display("FAIL rstmid_led got=%h exp=00", led_out); end
    checks++; if (cmd_err !== 1'b0) begin failures++; $display("FAIL rstmid_width got=%b exp=0", cmd_err); end
  endtask

  task automatic test_random();
    logic [8:0] q[$];
    logic [8:0] it;
    int unsigned sel;
    int unsigned gap;
    logic [7:0] op;
    for (int c = 0; c < 60; c++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0) op = 8'h00;
      else if (sel <= 3) op = 8'h01;
      else if (sel <= 5) op = 8'h02;
      else if (sel <= 7) op = 8'h03;
      else op = 8'($urandom_range(4, 255));
      q.push_back({1'b1, op});
      if (op >= 8'h01 && op <= 8'h03) begin
        gap = ($urandom_range(0, 7) == 0) ? $urandom_range(48, 52) : $urandom_range(0, 3);
        for (int g = 0; g < int'(gap); g++) q.push_back({1'b0, 8'($urandom)});
        if (op == 8'h01) q.push_back({1'b1, 8'($urandom)});
        else q.push_back({1'b1, 8'($urandom_range(0, 3))});
      end
      gap = $urandom_range(0, 24);
      for (int g = 0; g < int'(gap); g++) q.push_back({1'b0, 8'($urandom)});
    end
    while (q.size() > 0) begin
      it = q.pop_front();
      write_done = it[8];
      byte_in    = it[7:0];
      @(negedge clk);
      checks++; if (led_out !== m_led) begin failures++; $display("FAIL rnd_led edge=%0d got=%h exp=%h", edge_n, led_out, m_led); end
      checks++; if (mode !== m_mode) begin failures++; $display("FAIL rnd_mode edge=%0d got=%b exp=%b", edge_n, mode, m_mode); end
      checks++; if (cmd_err !== m_err) begin failures++; $display("FAIL rnd_err edge=%0d got=%b exp=%b", edge_n, cmd_err, m_err); end
    end
    write_done = 1'b0;
  endtask

  initial begin
    test_reset();
    test_set();
    test_rotate();
    test_blink();
    test_errors();
    test_boundaries();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
